// File: rtl/alu_seq_ctrl.sv
// Sequences one command at a time through an external ALU/NZCV datapath: condition check,
// multi-cycle multiply, flag/result commit and result hold. Optional perf counters: ALU_SEQ_PERF_EN.
module alu_seq_ctrl #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic             cmd_s_bit,
    input  logic [3:0]       cmd_cond,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [3:0]       alu_opcode,
    output logic             alu_s_bit,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    input  logic             flags_ld,
    input  logic [3:0]       flags_ld_d,
    output logic [3:0]       flags,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_we
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]      perf_exec,
    output logic [15:0]      perf_skip
`endif
);

    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_CMP = 4'b1000;
    localparam logic [3:0] OP_NOP = 4'b1111;
    localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
    localparam int         CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_MWAIT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [3:0]       cond_r;
    logic [CNT_W-1:0] cnt_r;
    logic             accept_s;
    logic             commit_s;
    logic             skip_s;
    logic             cnt_load_s;
    logic             cnt_dec_s;

    // Flags are packed {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c && !z;
            4'h9:    cond_pass = !c || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        commit_s   = 1'b0;
        skip_s     = 1'b0;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept_s = 1'b1;
                    state_s  = S_EXEC;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_EXEC: begin
                if (!cond_pass(cond_r, flags) || (alu_opcode == OP_NOP)) begin
                    skip_s  = 1'b1;
                    state_s = S_DONE;
                end else if ((alu_opcode == OP_MUL) && MUL_MULTI) begin
                    cnt_load_s = 1'b1;
                    state_s    = S_MWAIT;
                end else begin
                    commit_s = 1'b1;
                    state_s  = S_DONE;
                end
            end
            S_MWAIT: begin
                if (cnt_r == CNT_ONE) begin
                    commit_s = 1'b1;
                    state_s  = S_DONE;
                end else begin
                    cnt_dec_s = 1'b1;
                    state_s   = S_MWAIT;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register plus registered handshake outputs that track it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
        end else begin
            state_r   <= state_s;
            cmd_ready <= (state_s == S_IDLE);
            res_valid <= (state_s == S_DONE);
        end
    end

    // Command capture into the ALU-facing operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1    <= {WIDTH{1'b0}};
            alu_in2    <= {WIDTH{1'b0}};
            alu_opcode <= 4'b0000;
            alu_s_bit  <= 1'b0;
            cond_r     <= 4'b0000;
        end else if (accept_s) begin
            alu_in1    <= cmd_a;
            alu_in2    <= cmd_b;
            alu_opcode <= cmd_opcode;
            alu_s_bit  <= cmd_s_bit;
            cond_r     <= cmd_cond;
        end
    end

    // Multiply stretch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_load_s) begin
            cnt_r <= CNT_INIT;
        end else if (cnt_dec_s) begin
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

    // Architectural flags: direct load only while idle, so it never races a commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if ((state_r == S_IDLE) && flags_ld) begin
            flags <= flags_ld_d;
        end else if (commit_s && alu_s_bit) begin
            flags <= alu_flags;
        end
    end

    // Result commit; skipped ops clear the result so no stale write-back is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= {WIDTH{1'b0}};
            res_we   <= 1'b0;
        end else if (commit_s) begin
            res_data <= alu_result;
            res_we   <= (alu_opcode != OP_CMP);
        end else if (skip_s) begin
            res_data <= {WIDTH{1'b0}};
            res_we   <= 1'b0;
        end
    end

`ifdef ALU_SEQ_PERF_EN
    // Saturating commit and skip counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_exec <= 16'h0000;
            perf_skip <= 16'h0000;
        end else begin
            if (commit_s && (perf_exec != 16'hFFFF)) begin
                perf_exec <= perf_exec + 16'h0001;
            end
            if (skip_s && (perf_skip != 16'hFFFF)) begin
                perf_skip <= perf_skip + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: a behavioural ALU answers the DUT's operand bus, and
// expected result/write-enable/flags/latency are queued at issue and checked at res_valid.
module tb_alu_seq_ctrl;

    localparam int         MUL_CYC = 3;
    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] MUL = 4'b0010;
    localparam logic [3:0] CMP = 4'b1000;
    localparam logic [3:0] MOV = 4'b1101;
    localparam logic [3:0] NOP = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_s_bit;
    logic [3:0]  cmd_opcode, cmd_cond;
    logic [31:0] cmd_a, cmd_b;
    logic [31:0] alu_in1, alu_in2, alu_result;
    logic [3:0]  alu_opcode, alu_flags;
    logic        alu_s_bit;
    logic        flags_ld;
    logic [3:0]  flags_ld_d, flags;
    logic        res_valid, res_ready, res_we;
    logic [31:0] res_data;

    typedef struct {
        logic [31:0] d;
        logic        we;
        logic [3:0]  f;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mflags;
    int         total = 0;
    int         bad = 0;

    alu_seq_ctrl #(.WIDTH(32), .MUL_CYCLES(MUL_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_s_bit(cmd_s_bit), .cmd_cond(cmd_cond), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode), .alu_s_bit(alu_s_bit),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .flags_ld(flags_ld), .flags_ld_d(flags_ld_d), .flags(flags),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_we(res_we)
    );

    always #5 clk = ~clk;

    // Returns {N,Z,C,V, result}; C on subtract is the borrow.
    function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        w = 33'd0; r = 32'd0; c = 1'b0; v = 1'b0;
        case (op)
            ADD: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0]; c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            SUB, CMP: begin
                r = a - b; c = (a < b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            MUL: r = a * b;
            MOV: r = b;
            default: r = 32'd0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;          4'h1: return ~z;
            4'h2: return c;          4'h3: return ~c;
            4'h4: return n;          4'h5: return ~n;
            4'h6: return v;          4'h7: return ~v;
            4'h8: return c & ~z;     4'h9: return ~c | z;
            4'hA: return n ~^ v;     4'hB: return n ^ v;
            4'hC: return ~z & (n ~^ v);
            4'hD: return z | (n ^ v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb {alu_flags, alu_result} = alu_model(alu_opcode, alu_in1, alu_in2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic s, input logic [3:0] cc,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic ld, input logic [3:0] ld_d, input int hold, input bit pulse);
        exp_t        e;
        exp_t        g;
        logic [35:0] m;
        int          lat;
        bit          pass;
        if (ld) mflags = ld_d;
        m    = alu_model(op, a, b);
        pass = cond_ok(cc, mflags) && (op != NOP);
        e.d  = pass ? m[31:0] : 32'd0;
        e.we = pass && (op != CMP);
        if (pass && s) mflags = m[35:32];
        e.f   = mflags;
        e.lat = (pass && op == MUL) ? 1 + MUL_CYC : 2;
        sb.push_back(e);

        @(negedge clk);
        check("ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_s_bit = s; cmd_cond = cc;
        cmd_a = a; cmd_b = b; flags_ld = ld; flags_ld_d = ld_d;
        @(posedge clk); #1;
        cmd_valid = 1'b0; flags_ld = 1'b0;
        lat = 1;
        check("busy_exec", {31'd0, cmd_ready}, 32'd0);
        while (!res_valid && lat < 40) begin
            if (pulse && lat == 2) begin
                cmd_valid = 1'b1; cmd_a = 32'd99; flags_ld = 1'b1; flags_ld_d = 4'b1111;
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0; flags_ld = 1'b0;
            lat++;
            if (!res_valid) check("busy_wait", {31'd0, cmd_ready}, 32'd0);
        end
        check("res_valid_seen", {31'd0, res_valid}, 32'd1);
        if (sb.size() > 0) begin
            g = sb.pop_front();
            check("latency", lat, g.lat);
            check("res_data", res_data, g.d);
            check("res_we", {31'd0, res_we}, {31'd0, g.we});
            check("flags", {28'd0, flags}, {28'd0, g.f});
            check("ready_done", {31'd0, cmd_ready}, 32'd0);
            if (pulse) check("operand_kept", alu_in1, a);
            for (int i = 0; i < hold; i++) begin
                flags_ld = 1'b1; flags_ld_d = ~g.f;
                @(posedge clk); #1;
                flags_ld = 1'b0;
                check("hold_valid", {31'd0, res_valid}, 32'd1);
                check("hold_data", res_data, g.d);
                check("hold_flags", {28'd0, flags}, {28'd0, g.f});
                check("hold_ready", {31'd0, cmd_ready}, 32'd0);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("back_idle", {31'd0, cmd_ready}, 32'd1);
        check("valid_drop", {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        logic [3:0] ops [6];
        ops[0] = ADD; ops[1] = SUB; ops[2] = MUL; ops[3] = MOV; ops[4] = CMP; ops[5] = NOP;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_s_bit = 1'b0; cmd_cond = 4'd0;
        cmd_a = 32'd0; cmd_b = 32'd0; flags_ld = 1'b0; flags_ld_d = 4'd0; res_ready = 1'b0;
        mflags = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_data", res_data, 32'd0);
        check("rst_we", {31'd0, res_we}, 32'd0);
        check("rst_in1", alu_in1, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op(ADD, 1'b1, 4'hE, 32'd5, 32'd3, 1'b0, 4'd0, 0, 1'b0);
        run_op(SUB, 1'b1, 4'hE, 32'd3, 32'd3, 1'b0, 4'd0, 0, 1'b0);
        run_op(MOV, 1'b0, 4'h0, 32'd0, 32'h55, 1'b0, 4'd0, 0, 1'b0);
        run_op(MOV, 1'b0, 4'h1, 32'd0, 32'h55, 1'b0, 4'd0, 0, 1'b0);
        run_op(MUL, 1'b0, 4'hE, 32'd6, 32'd7, 1'b0, 4'd0, 0, 1'b1);
        run_op(ADD, 1'b1, 4'hE, 32'h7FFFFFFF, 32'd1, 1'b0, 4'd0, 5, 1'b0);
        run_op(NOP, 1'b1, 4'hE, 32'd1, 32'd2, 1'b0, 4'd0, 0, 1'b0);
        run_op(SUB, 1'b1, 4'hE, 32'd2, 32'd5, 1'b0, 4'd0, 0, 1'b0);
        run_op(CMP, 1'b1, 4'hA, 32'd2, 32'd5, 1'b1, 4'b1001, 0, 1'b0);
        run_op(MUL, 1'b1, 4'hF, 32'd6, 32'd7, 1'b0, 4'd0, 0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            run_op(ops[$urandom_range(5, 0)], 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
                   32'($urandom_range(40, 0)), 32'($urandom_range(40, 0)),
                   1'($urandom_range(3, 0) == 0), 4'($urandom_range(15, 0)), 0, 1'b0);
        end

        run_op(SUB, 1'b1, 4'hE, 32'd1, 32'd9, 1'b0, 4'd0, 0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = MUL; cmd_s_bit = 1'b1; cmd_cond = 4'hE;
        cmd_a = 32'd6; cmd_b = 32'd7;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("mwait_busy", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        mflags = 4'd0;
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_valid", {31'd0, res_valid}, 32'd0);
        check("abort_flags", {28'd0, flags}, 32'd0);
        check("abort_in1", alu_in1, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("no_commit_valid", {31'd0, res_valid}, 32'd0);
        check("no_commit_data", res_data, 32'd0);
        check("no_commit_flags", {28'd0, flags}, 32'd0);
        run_op(ADD, 1'b1, 4'hE, 32'd5, 32'd3, 1'b0, 4'd0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
